// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display between NUM_REQ producers.
// Define DISPLAY_ARB_TAG_EN to replace the leftmost digit with the source requester index.
module display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_REQ-1:0]     req_valid_in,
    input  logic [32*NUM_REQ-1:0]  req_val_in,
    output logic [NUM_REQ-1:0]     req_ready_out,
    output logic [31:0]            val_out,
    output logic [2:0]             owner_out,
    output logic                   busy_out
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   owner_idx;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   sel_idx;
    logic            grant_hit;
    logic            xfer;
    logic [31:0]     sel_val;
    logic [31:0]     latch_val;

    // Index reached by stepping 'step' places after 'base', wrapping at NUM_REQ.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PW'(sum);
    endfunction

    assign owner_idx = owner_out[PW-1:0];

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_hit && req_valid_in[rr_idx(ptr, k)]) begin
                grant_hit = 1'b1;
                grant_idx = rr_idx(ptr, k);
            end
        end
    end

    always_comb begin
        state_next    = state;
        req_ready_out = '0;
        sel_idx       = owner_idx;
        case (state)
            IDLE: begin
                sel_idx = grant_idx;
                if (grant_hit) begin
                    req_ready_out[grant_idx] = 1'b1;
                    state_next               = SHOW;
                end
            end
            SHOW: begin
                req_ready_out[owner_idx] = req_valid_in[owner_idx];
                if (cnt == HOLD_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Ready must be silent for the whole reset pulse, not just after the first edge.
        if (rst_in) req_ready_out = '0;
    end

    assign xfer    = |(req_valid_in & req_ready_out);
    assign sel_val = req_val_in[32*int'(sel_idx) +: 32];

`ifdef DISPLAY_ARB_TAG_EN
    assign latch_val = {1'b0, 3'(sel_idx), sel_val[27:0]};
`else
    assign latch_val = sel_val;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            cnt       <= '0;
            val_out   <= '0;
            owner_out <= '0;
            busy_out  <= 1'b0;
        end else begin
            state    <= state_next;
            busy_out <= (state_next == SHOW);
            if (xfer) begin
                val_out   <= latch_val;
                owner_out <= 3'(sel_idx);
            end
            // Owner refreshes during SHOW leave the dwell counter running.
            if (state == IDLE) begin
                if (xfer) ptr <= grant_idx;
                cnt <= '0;
            end else if (cnt != HOLD_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=4, HOLD_CYCLES=8.
module tb_display_arbiter;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [3:0]    req_valid_in;
    logic [127:0]  req_val_in;
    logic [3:0]    req_ready_out;
    logic [31:0]   val_out;
    logic [2:0]    owner_out;
    logic          busy_out;
    logic [31:0]   vals [4];

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    assign req_val_in = {vals[3], vals[2], vals[1], vals[0]};

    display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(8)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_val_in    (req_val_in),
        .req_ready_out (req_ready_out),
        .val_out       (val_out),
        .owner_out     (owner_out),
        .busy_out      (busy_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] tagv(input int idx, input logic [31:0] v);
`ifdef DISPLAY_ARB_TAG_EN
        return {4'(idx), v[27:0]};
`else
        return v;
`endif
    endfunction

    initial begin
        logic [31:0] rr_vals [4];
        rr_vals[0] = 32'hA0000010;
        rr_vals[1] = 32'hB1000011;
        rr_vals[2] = 32'hC2000012;
        rr_vals[3] = 32'hD3000013;
        rst_in = 1'b1;
        req_valid_in = 4'b0000;
        for (int i = 0; i < 4; i++) vals[i] = 32'h0;

        // Reset state
        tick(3);
        chk("rst_val", val_out, 32'h0);
        chk("rst_owner", {29'h0, owner_out}, 32'h0);
        chk("rst_busy", {31'h0, busy_out}, 32'h0);
        req_valid_in = 4'b1111;
        #1;
        chk("rst_ready_masked", {28'h0, req_ready_out}, 32'h0);
        req_valid_in = 4'b0000;
        rst_in = 1'b0;
        tick(1);

        // Single requester 1
        vals[1] = 32'hDEADBEEF;
        req_valid_in = 4'b0010;
        #1;
        chk("single_ready", {28'h0, req_ready_out}, 32'h2);
        tick(1);
        chk("single_val", val_out, tagv(1, 32'hDEADBEEF));
        chk("single_owner", {29'h0, owner_out}, 32'h1);
        chk("single_busy", {31'h0, busy_out}, 32'h1);
        req_valid_in = 4'b0000;
        tick(7);
        chk("single_busy_last", {31'h0, busy_out}, 32'h1);
        tick(1);
        chk("single_busy_fall", {31'h0, busy_out}, 32'h0);
        chk("single_val_hold", val_out, tagv(1, 32'hDEADBEEF));

        // Owner update mid-SHOW, other requester blocked
        vals[2] = 32'hAAAA0002;
        req_valid_in = 4'b0100;
        #1;
        chk("upd_ready_grant", {28'h0, req_ready_out}, 32'h4);
        tick(1);
        chk("upd_val_first", val_out, tagv(2, 32'hAAAA0002));
        chk("upd_owner", {29'h0, owner_out}, 32'h2);
        vals[3] = 32'h33333333;
        req_valid_in = 4'b1000;
        #1;
        chk("upd_ready_blocked", {28'h0, req_ready_out}, 32'h0);
        tick(3);
        vals[2] = 32'h12345678;
        req_valid_in = 4'b1100;
        #1;
        chk("upd_ready_owner", {28'h0, req_ready_out}, 32'h4);
        tick(1);
        chk("upd_val_new", val_out, tagv(2, 32'h12345678));
        chk("upd_busy", {31'h0, busy_out}, 32'h1);
        req_valid_in = 4'b1000;
        tick(3);
        chk("upd_busy_last", {31'h0, busy_out}, 32'h1);
        chk("upd_ready_last", {28'h0, req_ready_out}, 32'h0);
        tick(1);
        chk("upd_busy_end", {31'h0, busy_out}, 32'h0);
        chk("upd_ready_idle", {28'h0, req_ready_out}, 32'h8);

        // Grant 3, then owner transfer on the final SHOW cycle
        tick(1);
        chk("g3_owner", {29'h0, owner_out}, 32'h3);
        chk("g3_val", val_out, tagv(3, 32'h33333333));
        req_valid_in = 4'b0000;
        tick(7);
        vals[3] = 32'hFFFFFFFF;
        req_valid_in = 4'b1000;
        #1;
        chk("final_ready", {28'h0, req_ready_out}, 32'h8);
        tick(1);
        chk("final_busy", {31'h0, busy_out}, 32'h0);
        chk("final_val_tag", val_out, tagv(3, 32'hFFFFFFFF));
        req_valid_in = 4'b0000;

        // Reset asserted mid-SHOW with owner 2
        vals[2] = 32'h55550002;
        req_valid_in = 4'b0100;
        tick(1);
        chk("pre_rst_owner", {29'h0, owner_out}, 32'h2);
        tick(3);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_val", val_out, 32'h0);
        chk("mid_rst_owner", {29'h0, owner_out}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy_out}, 32'h0);
        chk("mid_rst_ready", {28'h0, req_ready_out}, 32'h0);
        tick(1);
        rst_in = 1'b0;

        // Round-robin with all four held valid
        for (int i = 0; i < 4; i++) vals[i] = rr_vals[i];
        req_valid_in = 4'b1111;
        #1;
        chk("rr_first_ready", {28'h0, req_ready_out}, 32'h1);
        for (int g = 0; g < 5; g++) begin
            tick(1);
            chk($sformatf("rr_owner%0d", g), {29'h0, owner_out}, 32'(g % 4));
            chk($sformatf("rr_val%0d", g), val_out, tagv(g % 4, rr_vals[g % 4]));
            tick(8);
            chk($sformatf("rr_idle_busy%0d", g), {31'h0, busy_out}, 32'h0);
            chk($sformatf("rr_next_ready%0d", g), {28'h0, req_ready_out},
                32'(1 << ((g + 1) % 4)));
        end
        req_valid_in = 4'b0000;

        // Idle hold of the last value
        vals[1] = 32'hCAFE0001;
        req_valid_in = 4'b0010;
        #1;
        chk("idle_grant_ready", {28'h0, req_ready_out}, 32'h2);
        tick(1);
        chk("idle_grant_val", val_out, tagv(1, 32'hCAFE0001));
        req_valid_in = 4'b0000;
        tick(20);
        chk("idle_hold_val", val_out, tagv(1, 32'hCAFE0001));
        chk("idle_hold_busy", {31'h0, busy_out}, 32'h0);
        chk("idle_hold_owner", {29'h0, owner_out}, 32'h1);
        chk("idle_hold_ready", {28'h0, req_ready_out}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
